// File: rtl/addr_gen_dec_ext_ram.sv
// addr_gen_dec_ext_ram: memory/addressing core of one LDPC decoder PE.
//   - three circulant address generators (mod-L counters with per-generator start offsets)
//   - three extrinsic-message RAMs sharing we/cs, with independent addresses and data
//   - two fully independent hard-decision RAM banks (ping-pong)
// Optional feature macro: MEM_RESET_CLEAR_EN -- when defined, reset also zeroes every RAM word.
// Reset is synchronous and active-low; all logic runs on posedge clk.

// Single-port synchronous RAM with a registered read port.
module addr_gen_dec_ext_ram_spram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] add,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_reg;
    logic                  add_known;

    // An address with unknown bits must never land a write on some arbitrary word.
    assign add_known = !$isunknown(add);

    // Storage array: write on cs&we; reset takes precedence over any write.
    always_ff @(posedge clk) begin
`ifdef MEM_RESET_CLEAR_EN
        if (!reset) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (cs && we && add_known) begin
            mem[add] <= data_in;
        end
`else
        if (reset && cs && we && add_known) begin
            mem[add] <= data_in;
        end
`endif
    end

    // Read register: loads on a read access, otherwise holds its last value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_reg <= '0;
        end else if (cs && !we) begin
            rd_reg <= mem[add];
        end
    end

    assign data_out = rd_reg;
endmodule

module addr_gen_dec_ext_ram #(
    parameter int L              = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int COUNT_FROM_1   = 0,
    parameter int COUNT_FROM_2   = 0,
    parameter int COUNT_FROM_3   = 0,
    parameter int MESSAGE_WIDTH  = 5,
    parameter int DECISION_WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ag_en,
    input  logic                           ag_restart,
    output logic [3*ADDR_WIDTH-1:0]        ag_out,
    output logic                           ag_last,
    input  logic [3*ADDR_WIDTH-1:0]        ext_add,
    input  logic                           ext_we,
    input  logic                           ext_cs,
    input  logic [3*(MESSAGE_WIDTH+1)-1:0] ext_data_in,
    output logic [3*(MESSAGE_WIDTH+1)-1:0] ext_data_out,
    input  logic [2*ADDR_WIDTH-1:0]        dec_add,
    input  logic [1:0]                     dec_we,
    input  logic [1:0]                     dec_cs,
    input  logic [2*DECISION_WIDTH-1:0]    dec_data_in,
    output logic [2*DECISION_WIDTH-1:0]    dec_data_out
);
    localparam int EXT_WIDTH = MESSAGE_WIDTH + 1;

    // Start offsets of the three generators, generator n in slice n.
    localparam logic [3*ADDR_WIDTH-1:0] START = {
        ADDR_WIDTH'(COUNT_FROM_3), ADDR_WIDTH'(COUNT_FROM_2), ADDR_WIDTH'(COUNT_FROM_1)
    };
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(L - 1);

    genvar gi;

    // Circulant address generators: each wraps L-1 -> 0 on its own, so the
    // relative offsets between them stay constant modulo L.
    for (gi = 0; gi < 3; gi++) begin : g_gen
        logic [ADDR_WIDTH-1:0] cnt_reg;
        logic [ADDR_WIDTH-1:0] cnt_next;

        // Next count: restart beats enable, otherwise hold.
        always_comb begin
            cnt_next = cnt_reg;
            if (ag_restart) begin
                cnt_next = START[gi*ADDR_WIDTH +: ADDR_WIDTH];
            end else if (ag_en) begin
                cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + ADDR_WIDTH'(1);
            end
        end

        // Count register, reloaded with the start offset on reset.
        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt_reg <= START[gi*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                cnt_reg <= cnt_next;
            end
        end

        assign ag_out[gi*ADDR_WIDTH +: ADDR_WIDTH] = cnt_reg;
    end

    // Generator 0 defines the phase; flag its final address.
    assign ag_last = (ag_out[ADDR_WIDTH-1:0] == LAST);

    // Extrinsic-message RAMs: one per edge of a weight-3 column, accessed in lockstep.
    for (gi = 0; gi < 3; gi++) begin : g_ext
        addr_gen_dec_ext_ram_spram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (EXT_WIDTH)
        ) u_ram (
            .clk      (clk),
            .reset    (reset),
            .cs       (ext_cs),
            .we       (ext_we),
            .add      (ext_add[gi*ADDR_WIDTH +: ADDR_WIDTH]),
            .data_in  (ext_data_in[gi*EXT_WIDTH +: EXT_WIDTH]),
            .data_out (ext_data_out[gi*EXT_WIDTH +: EXT_WIDTH])
        );
    end

    // Hard-decision ping-pong banks: separate storage, so one can be written while the other is read.
    for (gi = 0; gi < 2; gi++) begin : g_dec
        addr_gen_dec_ext_ram_spram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DECISION_WIDTH)
        ) u_ram (
            .clk      (clk),
            .reset    (reset),
            .cs       (dec_cs[gi]),
            .we       (dec_we[gi]),
            .add      (dec_add[gi*ADDR_WIDTH +: ADDR_WIDTH]),
            .data_in  (dec_data_in[gi*DECISION_WIDTH +: DECISION_WIDTH]),
            .data_out (dec_data_out[gi*DECISION_WIDTH +: DECISION_WIDTH])
        );
    end
endmodule

// File: tb/tb_addr_gen_dec_ext_ram.sv
// Directed testbench for addr_gen_dec_ext_ram (L=32, generator offsets 0/7/21).
// Honours MEM_RESET_CLEAR_EN when choosing the expected post-reset RAM contents.
module tb_addr_gen_dec_ext_ram;
    localparam int AW = 5;
    localparam int EW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          ag_en;
    logic          ag_restart;
    logic [3*AW-1:0] ag_out;
    logic          ag_last;
    logic [3*AW-1:0] ext_add;
    logic          ext_we;
    logic          ext_cs;
    logic [3*EW-1:0] ext_data_in;
    logic [3*EW-1:0] ext_data_out;
    logic [2*AW-1:0] dec_add;
    logic [1:0]    dec_we;
    logic [1:0]    dec_cs;
    logic [1:0]    dec_data_in;
    logic [1:0]    dec_data_out;

    int n_cmp = 0;
    int n_mis = 0;
    int st[3] = '{0, 7, 21};

    addr_gen_dec_ext_ram #(
        .L(32), .ADDR_WIDTH(AW), .COUNT_FROM_1(0), .COUNT_FROM_2(7), .COUNT_FROM_3(21),
        .MESSAGE_WIDTH(5), .DECISION_WIDTH(1)
    ) dut (
        .clk(clk), .reset(reset), .ag_en(ag_en), .ag_restart(ag_restart),
        .ag_out(ag_out), .ag_last(ag_last),
        .ext_add(ext_add), .ext_we(ext_we), .ext_cs(ext_cs),
        .ext_data_in(ext_data_in), .ext_data_out(ext_data_out),
        .dec_add(dec_add), .dec_we(dec_we), .dec_cs(dec_cs),
        .dec_data_in(dec_data_in), .dec_data_out(dec_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_mem;
        reset = 1'b0; ag_en = 1'b0; ag_restart = 1'b0;
        ext_add = '0; ext_we = 1'b0; ext_cs = 1'b0; ext_data_in = '0;
        dec_add = '0; dec_we = 2'b00; dec_cs = 2'b00; dec_data_in = 2'b00;
        tick();
        tick();
        check("rst ag_out", ag_out, {5'd21, 5'd7, 5'd0});
        check("rst ag_last", ag_last, 0);
        check("rst ext_out", ext_data_out, 0);
        check("rst dec_out", dec_data_out, 0);

        // T1: free-running count, generator 2 wraps at k=11, generator 0 at k=32
        reset = 1'b1; ag_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            for (int n = 0; n < 3; n++) begin
                check($sformatf("t1 k%0d g%0d", k, n), ag_out[n*AW +: AW], (st[n] + k) % 32);
            end
            check($sformatf("t1 k%0d last", k), ag_last, ((st[0] + k) % 32) == 31);
        end

        // T2: run gen0 from 8 up to 13, then restart together with enable
        for (int k = 0; k < 5; k++) tick();
        check("t2 g0 at 13", ag_out[AW-1:0], 13);
        ag_restart = 1'b1;
        tick();
        check("t2 restart", ag_out, {5'd21, 5'd7, 5'd0});
        ag_restart = 1'b0; ag_en = 1'b0;
        tick(); tick(); tick();
        check("t2 hold", ag_out, {5'd21, 5'd7, 5'd0});

        // T3: EXT write 3/4/5, then read back, then cs=0 holds
        ext_cs = 1'b1; ext_we = 1'b1;
        ext_add = {5'd5, 5'd4, 5'd3};
        ext_data_in = {6'h3F, 6'h15, 6'h2A};
        tick();
        check("t3 write holds out", ext_data_out, 0);
        ext_we = 1'b0; ext_data_in = '0;
        tick();
        check("t3 read", ext_data_out, {6'h3F, 6'h15, 6'h2A});
        ext_cs = 1'b0; ext_add = {5'd0, 5'd0, 5'd0};
        tick();
        check("t3 cs0 holds", ext_data_out, {6'h3F, 6'h15, 6'h2A});

        // T4: DEC banks are independent storage
        dec_cs = 2'b10; dec_we = 2'b10; dec_add = {5'd9, 5'd0}; dec_data_in = 2'b00;
        tick();
        dec_cs = 2'b11; dec_we = 2'b01; dec_add = {5'd9, 5'd9}; dec_data_in = 2'b01;
        tick();
        check("t4 b0 wr b1 rd", dec_data_out, 2'b00);
        dec_cs = 2'b01; dec_we = 2'b00; dec_data_in = 2'b00;
        tick();
        check("t4 b0 rd", dec_data_out, 2'b01);
        dec_cs = 2'b11; dec_we = 2'b11; dec_add = {5'd20, 5'd20}; dec_data_in = 2'b10;
        tick();
        dec_we = 2'b00; dec_data_in = 2'b00;
        tick();
        check("t4 both rd 20", dec_data_out, 2'b10);
        dec_add = {5'd9, 5'd9};
        tick();
        check("t4 both rd 9", dec_data_out, 2'b01);
        dec_cs = 2'b00;

        // T5: reset clears read registers and generators; memory per build option
        ext_cs = 1'b1; ext_we = 1'b1;
        ext_add = {5'd31, 5'd31, 5'd31}; ext_data_in = {6'h11, 6'h11, 6'h11};
        tick();
        ext_add = {5'd30, 5'd30, 5'd30}; ext_data_in = {6'h05, 6'h05, 6'h05};
        tick();
        ext_we = 1'b0; ext_add = {5'd31, 5'd31, 5'd31};
        ag_en = 1'b1;
        tick();
        check("t5 pre-rst read", ext_data_out, {6'h11, 6'h11, 6'h11});
        check("t5 pre-rst ag", ag_out, {5'd22, 5'd8, 5'd1});
        // Reset cycle with a competing write and enable: reset must win
        reset = 1'b0; ext_we = 1'b1;
        ext_add = {5'd30, 5'd30, 5'd30}; ext_data_in = {6'h3F, 6'h3F, 6'h3F};
        dec_cs = 2'b11; dec_we = 2'b11; dec_add = {5'd20, 5'd20}; dec_data_in = 2'b01;
        tick();
        check("t5 rst ext_out", ext_data_out, 0);
        check("t5 rst ag_out", ag_out, {5'd21, 5'd7, 5'd0});
        check("t5 rst dec_out", dec_data_out, 0);
        reset = 1'b1; ag_en = 1'b0; ext_we = 1'b0; ext_data_in = '0;
        ext_add = {5'd31, 5'd31, 5'd31};
        dec_we = 2'b00; dec_data_in = 2'b00;
        tick();
`ifdef MEM_RESET_CLEAR_EN
        exp_mem = 0;
        check("t5 rd 31", ext_data_out, exp_mem);
        ext_add = {5'd30, 5'd30, 5'd30};
        tick();
        check("t5 rd 30", ext_data_out, exp_mem);
        check("t5 dec rd 20", dec_data_out, 2'b00);
`else
        exp_mem = {6'h11, 6'h11, 6'h11};
        check("t5 rd 31", ext_data_out, exp_mem);
        ext_add = {5'd30, 5'd30, 5'd30};
        tick();
        exp_mem = {6'h05, 6'h05, 6'h05};
        check("t5 rd 30", ext_data_out, exp_mem);
        check("t5 dec rd 20", dec_data_out, 2'b10);
`endif
        check("t5 ag stable", ag_out, {5'd21, 5'd7, 5'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
